// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the register-file write arbiter.
//   arb_state_t : 2-bit FSM state encodings ARB_IDLE / ARB_PENDING /
//                 ARB_STALL / ARB_ACK
//   REG_ZERO    : architectural zero register index (writes are dropped)
//   slot_free() : true when the writeback stage does not occupy the write port
// -----------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_PENDING = 2'd1,
    ARB_STALL   = 2'd2,
    ARB_ACK     = 2'd3
  } arb_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A WB write to r0 is architecturally a no-op, so that cycle's port slot
  // can be given to a debug write.
  function automatic logic slot_free(input logic we, input logic [4:0] dst);
    return (!we) || (dst == REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the register file's single write port between the writeback stage
// and a debug/loader requester. WB writes pass through combinationally and
// always win; a debug write is latched and committed in the first free WB
// slot. After MAX_WAIT cycles without a free slot the front end is stalled
// until a bubble reaches writeback.
//
// Parameters
//   MAX_WAIT            cycles a latched debug write waits before stalling
//                       (1..255)
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   i_wb_write_data     [31:0] WB data
//   i_wb_write_register [4:0]  WB destination
//   i_wb_reg_write             WB enable
//   i_dbg_req                  debug request, held until o_dbg_ack
//   i_dbg_register      [4:0]  debug destination, sampled on acceptance
//   i_dbg_data          [31:0] debug data, sampled on acceptance
//   o_dbg_ack                  one-cycle pulse: debug write done
//   o_rf_write_data     [31:0] to register file
//   o_rf_write_register [4:0]  to register file
//   o_rf_reg_write             to register file
//   o_pipe_stall               stall request to the hazard unit
//   o_busy                     a debug write is latched and not yet acked
// Optional (macro REGFILE_ARB_FWD_EN):
//   o_fwd_valid, o_fwd_register [4:0], o_fwd_data [31:0]
//                       registered copy of the debug write committed in the
//                       previous cycle, for an ID-stage bypass
// -----------------------------------------------------------------------------
module regfile_write_arbiter
  import mips_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_wb_write_data,
  input  logic [4:0]  i_wb_write_register,
  input  logic        i_wb_reg_write,
  input  logic        i_dbg_req,
  input  logic [4:0]  i_dbg_register,
  input  logic [31:0] i_dbg_data,
  output logic        o_dbg_ack,
  output logic [31:0] o_rf_write_data,
  output logic [4:0]  o_rf_write_register,
  output logic        o_rf_reg_write,
  output logic        o_pipe_stall,
  output logic        o_busy
`ifdef REGFILE_ARB_FWD_EN
  ,
  output logic        o_fwd_valid,
  output logic [4:0]  o_fwd_register,
  output logic [31:0] o_fwd_data
`endif
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  arb_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [4:0]        lat_register_reg, lat_register_next;
  logic [31:0]       lat_data_reg, lat_data_next;

  logic              wb_free;
  logic              commit;
  logic              ack;
  logic              stall;

  assign wb_free = slot_free(i_wb_reg_write, i_wb_write_register);

  // ---------------------------------------------------------------------------
  // State and latch registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ARB_IDLE;
      cnt_reg          <= '0;
      lat_register_reg <= '0;
      lat_data_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      lat_register_reg <= lat_register_next;
      lat_data_reg     <= lat_data_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    lat_register_next = lat_register_reg;
    lat_data_next     = lat_data_reg;
    commit            = 1'b0;
    ack               = 1'b0;
    stall             = 1'b0;

    case (state_reg)
      ARB_IDLE: begin
        if (i_dbg_req) begin
          lat_register_next = i_dbg_register;
          lat_data_next     = i_dbg_data;
          cnt_next          = '0;
          state_next        = ARB_PENDING;
        end
      end

      ARB_PENDING: begin
        if (lat_register_reg == REG_ZERO) begin
          // Writes to r0 are discarded: ack without touching the port.
          state_next = ARB_ACK;
        end else if (wb_free) begin
          commit     = 1'b1;
          state_next = ARB_ACK;
        end else if (cnt_reg == WAIT_LAST) begin
          state_next = ARB_STALL;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ARB_STALL: begin
        stall = 1'b1;
        if (wb_free) begin
          commit     = 1'b1;
          state_next = ARB_ACK;
        end
      end

      ARB_ACK: begin
        ack        = 1'b1;
        state_next = ARB_IDLE;
      end

      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write-port mux: a commit only happens on a free slot, so no WB write is
  // ever displaced.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (commit) begin
      o_rf_write_data     = lat_data_reg;
      o_rf_write_register = lat_register_reg;
      o_rf_reg_write      = 1'b1;
    end else begin
      o_rf_write_data     = i_wb_write_data;
      o_rf_write_register = i_wb_write_register;
      o_rf_reg_write      = i_wb_reg_write;
    end
  end

  assign o_dbg_ack    = ack;
  assign o_pipe_stall = stall;
  assign o_busy       = (state_reg != ARB_IDLE);

`ifdef REGFILE_ARB_FWD_EN
  // ---------------------------------------------------------------------------
  // Forwarding copy of the commit, visible during the ACK cycle.
  // ---------------------------------------------------------------------------
  logic        fwd_valid_reg;
  logic [4:0]  fwd_register_reg;
  logic [31:0] fwd_data_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_valid_reg    <= 1'b0;
      fwd_register_reg <= '0;
      fwd_data_reg     <= '0;
    end else begin
      fwd_valid_reg <= commit;
      if (commit) begin
        fwd_register_reg <= lat_register_reg;
        fwd_data_reg     <= lat_data_reg;
      end
    end
  end

  assign o_fwd_valid    = fwd_valid_reg;
  assign o_fwd_register = fwd_register_reg;
  assign o_fwd_data     = fwd_data_reg;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Every register-file write seen on the port is popped from a queue of
// expected writes filled as stimulus is driven; each scenario task also
// checks the control outputs cycle by cycle.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_we;
  logic        dbg_req;
  logic [4:0]  dbg_reg;
  logic [31:0] dbg_data;
  logic        o_dbg_ack;
  logic [31:0] o_rf_write_data;
  logic [4:0]  o_rf_write_register;
  logic        o_rf_reg_write;
  logic        o_pipe_stall;
  logic        o_busy;
`ifdef REGFILE_ARB_FWD_EN
  logic        o_fwd_valid;
  logic [4:0]  o_fwd_register;
  logic [31:0] o_fwd_data;
`endif

  regfile_write_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_wb_write_data     (wb_data),
    .i_wb_write_register (wb_reg),
    .i_wb_reg_write      (wb_we),
    .i_dbg_req           (dbg_req),
    .i_dbg_register      (dbg_reg),
    .i_dbg_data          (dbg_data),
    .o_dbg_ack           (o_dbg_ack),
    .o_rf_write_data     (o_rf_write_data),
    .o_rf_write_register (o_rf_write_register),
    .o_rf_reg_write      (o_rf_reg_write),
    .o_pipe_stall        (o_pipe_stall),
    .o_busy              (o_busy)
`ifdef REGFILE_ARB_FWD_EN
    ,
    .o_fwd_valid         (o_fwd_valid),
    .o_fwd_register      (o_fwd_register),
    .o_fwd_data          (o_fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_exp;
  int  checks = 0;
  int  errors = 0;

  // Scoreboard: every port write must match the next expected write.
  always @(negedge clk) begin
    if (o_rf_reg_write === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected: got r%0d=%h, required no write",
                 o_rf_write_register, o_rf_write_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({o_rf_write_register, o_rf_write_data} !== mon_exp) begin
          errors++;
          $display("FAIL rf_write: got r%0d=%h, required r%0d=%h",
                   o_rf_write_register, o_rf_write_data, mon_exp.r, mon_exp.d);
        end else begin
          $display("rf write r%0d = %h", o_rf_write_register, o_rf_write_data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.r = r;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic set_wb(input logic we, input logic [4:0] r, input logic [31:0] d);
    wb_we   = we;
    wb_reg  = r;
    wb_data = d;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    dbg_req = 1'b0;
    dbg_reg = 5'd0;
    dbg_data = 32'h0;
    set_wb(1'b0, 5'd17, 32'hA5A5_0001);
    step();
    step();
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", o_busy); end
    checks++; if (o_dbg_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b required 0", o_dbg_ack); end
    checks++; if (o_pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b required 0", o_pipe_stall); end
    checks++; if ({o_rf_reg_write, o_rf_write_register, o_rf_write_data} !== {1'b0, 5'd17, 32'hA5A5_0001}) begin
      errors++; $display("FAIL reset_mirror: got %b r%0d %h required 0 r17 a5a50001", o_rf_reg_write, o_rf_write_register, o_rf_write_data);
    end
`ifdef REGFILE_ARB_FWD_EN
    checks++; if ({o_fwd_valid, o_fwd_register, o_fwd_data} !== 38'd0) begin errors++; $display("FAIL reset_fwd: got %b r%0d %h required zeros", o_fwd_valid, o_fwd_register, o_fwd_data); end
`endif
    step();
    reset = 1'b0;
  endtask

  task automatic test_passthrough();
    set_wb(1'b1, 5'd5, 32'h0000_1234);
    push_wr(5'd5, 32'h0000_1234);
    @(negedge clk);
    checks++; if ({o_rf_reg_write, o_rf_write_register} !== {1'b1, 5'd5}) begin errors++; $display("FAIL pass_port: got %b r%0d required 1 r5", o_rf_reg_write, o_rf_write_register); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL pass_busy: got %b required 0", o_busy); end
    step();
    set_wb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_dbg_free();
    dbg_req = 1'b1; dbg_reg = 5'd7; dbg_data = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (o_rf_reg_write !== 1'b0) begin errors++; $display("FAIL free_c1_write: got %b required 0", o_rf_reg_write); end
    step();
    push_wr(5'd7, 32'hCAFE_F00D);
    @(negedge clk);
    checks++; if ({o_rf_reg_write, o_rf_write_register} !== {1'b1, 5'd7}) begin errors++; $display("FAIL free_c2_commit: got %b r%0d required 1 r7", o_rf_reg_write, o_rf_write_register); end
    checks++; if ({o_busy, o_dbg_ack} !== 2'b10) begin errors++; $display("FAIL free_c2_flags: got busy=%b ack=%b required 1 0", o_busy, o_dbg_ack); end
    step();
    @(negedge clk);
    checks++; if ({o_dbg_ack, o_rf_reg_write, o_busy} !== 3'b101) begin errors++; $display("FAIL free_c3_ack: got ack=%b we=%b busy=%b required 1 0 1", o_dbg_ack, o_rf_reg_write, o_busy); end
`ifdef REGFILE_ARB_FWD_EN
    checks++; if ({o_fwd_valid, o_fwd_register, o_fwd_data} !== {1'b1, 5'd7, 32'hCAFE_F00D}) begin errors++; $display("FAIL free_fwd: got %b r%0d %h required 1 r7 cafef00d", o_fwd_valid, o_fwd_register, o_fwd_data); end
`endif
    step();
    dbg_req = 1'b0;
    @(negedge clk);
    checks++; if ({o_busy, o_dbg_ack} !== 2'b00) begin errors++; $display("FAIL free_c4_idle: got busy=%b ack=%b required 0 0", o_busy, o_dbg_ack); end
`ifdef REGFILE_ARB_FWD_EN
    checks++; if (o_fwd_valid !== 1'b0) begin errors++; $display("FAIL free_fwd_drop: got %b required 0", o_fwd_valid); end
`endif
    step();
  endtask

  task automatic test_stall();
    dbg_req = 1'b1; dbg_reg = 5'd9; dbg_data = 32'h9999_0009;
    set_wb(1'b1, 5'd1, 32'd100); push_wr(5'd1, 32'd100);
    step();
    for (int i = 0; i < MAX_WAIT; i++) begin
      set_wb(1'b1, 5'(2 + i), 32'(200 + i)); push_wr(5'(2 + i), 32'(200 + i));
      @(negedge clk);
      checks++; if ({o_pipe_stall, o_busy} !== 2'b01) begin errors++; $display("FAIL stall_pending%0d: got stall=%b busy=%b required 0 1", i, o_pipe_stall, o_busy); end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      set_wb(1'b1, 5'(8 + i), 32'(300 + i)); push_wr(5'(8 + i), 32'(300 + i));
      @(negedge clk);
      checks++; if ({o_pipe_stall, o_dbg_ack} !== 2'b10) begin errors++; $display("FAIL stall_hold%0d: got stall=%b ack=%b required 1 0", i, o_pipe_stall, o_dbg_ack); end
      step();
    end
    set_wb(1'b0, 5'd11, 32'hDEAD_0011); push_wr(5'd9, 32'h9999_0009);
    @(negedge clk);
    checks++; if ({o_pipe_stall, o_rf_reg_write, o_rf_write_register} !== {2'b11, 5'd9}) begin errors++; $display("FAIL stall_commit: got stall=%b we=%b r%0d required 1 1 r9", o_pipe_stall, o_rf_reg_write, o_rf_write_register); end
    step();
    set_wb(1'b1, 5'd10, 32'd400); push_wr(5'd10, 32'd400);
    @(negedge clk);
    checks++; if ({o_pipe_stall, o_dbg_ack, o_rf_write_register} !== {2'b01, 5'd10}) begin errors++; $display("FAIL stall_ack: got stall=%b ack=%b r%0d required 0 1 r10", o_pipe_stall, o_dbg_ack, o_rf_write_register); end
    step();
    dbg_req = 1'b0; set_wb(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL stall_idle: got busy=%b required 0", o_busy); end
    step();
  endtask

  task automatic test_wb_r0();
    dbg_req = 1'b1; dbg_reg = 5'd12; dbg_data = 32'h1212_1212;
    set_wb(1'b1, 5'd3, 32'd33); push_wr(5'd3, 32'd33);
    step();
    push_wr(5'd3, 32'd34); set_wb(1'b1, 5'd3, 32'd34);
    @(negedge clk);
    checks++; if ({o_busy, o_dbg_ack} !== 2'b10) begin errors++; $display("FAIL r0slot_wait: got busy=%b ack=%b required 1 0", o_busy, o_dbg_ack); end
    step();
    set_wb(1'b1, 5'd0, 32'hDEAD_BEEF); push_wr(5'd12, 32'h1212_1212);
    @(negedge clk);
    checks++; if ({o_rf_reg_write, o_rf_write_register} !== {1'b1, 5'd12}) begin errors++; $display("FAIL r0slot_commit: got %b r%0d required 1 r12", o_rf_reg_write, o_rf_write_register); end
    step();
    set_wb(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (o_dbg_ack !== 1'b1) begin errors++; $display("FAIL r0slot_ack: got %b required 1", o_dbg_ack); end
    step();
    dbg_req = 1'b0;
  endtask

  task automatic test_dbg_r0();
    dbg_req = 1'b1; dbg_reg = 5'd0; dbg_data = 32'hFFFF_FFFF;
    step();
    set_wb(1'b1, 5'd6, 32'h66); push_wr(5'd6, 32'h66);
    @(negedge clk);
    checks++; if ({o_rf_write_register, o_rf_write_data, o_dbg_ack} !== {5'd6, 32'h66, 1'b0}) begin errors++; $display("FAIL dbgr0_pending: got r%0d %h ack=%b required r6 00000066 0", o_rf_write_register, o_rf_write_data, o_dbg_ack); end
    step();
    set_wb(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if ({o_dbg_ack, o_rf_reg_write} !== 2'b10) begin errors++; $display("FAIL dbgr0_ack: got ack=%b we=%b required 1 0", o_dbg_ack, o_rf_reg_write); end
`ifdef REGFILE_ARB_FWD_EN
    checks++; if (o_fwd_valid !== 1'b0) begin errors++; $display("FAIL dbgr0_fwd: got %b required 0", o_fwd_valid); end
`endif
    step();
    dbg_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    dbg_req = 1'b1; dbg_reg = 5'd20; dbg_data = 32'h2020_2020;
    step();
    push_wr(5'd20, 32'h2020_2020);
    @(negedge clk);
    checks++; if (o_rf_write_register !== 5'd20) begin errors++; $display("FAIL b2b_first: got r%0d required r20", o_rf_write_register); end
    step();
    dbg_reg = 5'd21; dbg_data = 32'h2121_2121;
    @(negedge clk);
    checks++; if (o_dbg_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1: got %b required 1", o_dbg_ack); end
    step();
    @(negedge clk);
    checks++; if ({o_busy, o_dbg_ack, o_rf_reg_write} !== 3'b000) begin errors++; $display("FAIL b2b_idle: got busy=%b ack=%b we=%b required 0 0 0", o_busy, o_dbg_ack, o_rf_reg_write); end
    step();
    push_wr(5'd21, 32'h2121_2121);
    @(negedge clk);
    checks++; if ({o_rf_write_register, o_rf_write_data} !== {5'd21, 32'h2121_2121}) begin errors++; $display("FAIL b2b_second: got r%0d %h required r21 21212121", o_rf_write_register, o_rf_write_data); end
    step();
    @(negedge clk);
    checks++; if (o_dbg_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2: got %b required 1", o_dbg_ack); end
    step();
    dbg_req = 1'b0;
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_done: got busy=%b required 0", o_busy); end
    step();
  endtask

  task automatic test_reset_stall();
    dbg_req = 1'b1; dbg_reg = 5'd15; dbg_data = 32'h1515_1515;
    set_wb(1'b1, 5'd1, 32'd500); push_wr(5'd1, 32'd500);
    step();
    for (int i = 0; i < MAX_WAIT; i++) begin
      set_wb(1'b1, 5'd2, 32'(600 + i)); push_wr(5'd2, 32'(600 + i));
      step();
    end
    set_wb(1'b1, 5'd3, 32'd700); push_wr(5'd3, 32'd700);
    @(negedge clk);
    checks++; if (o_pipe_stall !== 1'b1) begin errors++; $display("FAIL rststall_pre: got stall=%b required 1", o_pipe_stall); end
    reset = 1'b1;
    step();
    reset = 1'b0; dbg_req = 1'b0; set_wb(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if ({o_busy, o_pipe_stall, o_dbg_ack, o_rf_reg_write} !== 4'b0000) begin errors++; $display("FAIL rststall_post: got busy=%b stall=%b ack=%b we=%b required 0 0 0 0", o_busy, o_pipe_stall, o_dbg_ack, o_rf_reg_write); end
`ifdef REGFILE_ARB_FWD_EN
    checks++; if ({o_fwd_valid, o_fwd_register, o_fwd_data} !== 38'd0) begin errors++; $display("FAIL rststall_fwd: got %b r%0d %h required zeros", o_fwd_valid, o_fwd_register, o_fwd_data); end
`endif
    step();
    @(negedge clk);
    checks++; if (o_dbg_ack !== 1'b0) begin errors++; $display("FAIL rststall_noack: got %b required 0", o_dbg_ack); end
    step();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_dbg_free();
    test_stall();
    test_wb_r0();
    test_dbg_r0();
    test_back_to_back();
    test_reset_stall();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d writes outstanding required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
